// File: rtl/aes_key_schedule_iter.sv
// rtl/aes_key_schedule_iter.sv - iterative AES-128/192/256 key expansion, one word per clock

// Combinational AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // square-and-multiply to x^254 (zero maps to zero), then affine transform
  always_comb begin
    sq  = in_i;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_schedule_iter #(
  parameter  int KEY_LEN = 128,
  localparam int NK      = KEY_LEN / 32,
  localparam int NR      = NK + 6,
  localparam int NW      = 4 * (NR + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [KEY_LEN-1:0]      Secret_key,
  input  logic                    valid_in,
  output logic                    ready,
  output logic                    busy,
  output logic [(NR+1)*128-1:0]   key_expan,
  output logic [NR:0]             valid_out,
  output logic                    done
);

  localparam int IW = 6;
  localparam int MW = $clog2(NK);

  if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
    $error("aes_key_schedule_iter: KEY_LEN must be 128, 192 or 256");
  end

  logic                   busy_q;
  logic                   done_q;
  logic [IW-1:0]          idx_q;
  logic [MW-1:0]          mod_q;
  logic [7:0]             rcon_q;
  logic [NK-1:0][31:0]    win_q;     // last NK words, [0] is w[i-1], [NK-1] is w[i-NK]
  logic [(NR+1)*128-1:0]  ke_q;
  logic [NR:0]            vo_q;

  logic                   accept;
  logic [31:0]            prev_w;
  logic [31:0]            sub_in;
  logic [31:0]            sub_out;
  logic [31:0]            temp_w;
  logic [31:0]            word_d;
  logic [7:0]             rcon_d;
  logic [IW+4:0]          wr_off;

  assign accept = valid_in && !busy_q;
  assign prev_w = win_q[0];
  assign sub_in = (mod_q == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  assign rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  // word i of round r sits at bit (4r + 3 - i%4)*32, which is (i ^ 3)*32
  assign wr_off = {idx_q ^ IW'(3), 5'b00000};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sub_in[b*8 +: 8]),
      .out_o (sub_out[b*8 +: 8])
    );
  end

  // next schedule word from w[i-1] and w[i-NK]
  always_comb begin
    temp_w = prev_w;
    if (mod_q == '0) begin
      temp_w = sub_out ^ {rcon_q, 24'h000000};
    end else if (NK == 8 && mod_q == MW'(4)) begin
      temp_w = sub_out;
    end
    word_d = win_q[NK-1] ^ temp_w;
  end

  // key load, word generation, round-valid tracking and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
      mod_q  <= '0;
      rcon_q <= 8'h00;
      win_q  <= '0;
      ke_q   <= '0;
      vo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        busy_q <= 1'b1;
        idx_q  <= IW'(NK);
        mod_q  <= '0;
        rcon_q <= 8'h01;
        win_q  <= Secret_key;
        vo_q   <= (NK == 8) ? (NR+1)'(3) : (NR+1)'(1);
        for (int j = 0; j < NK; j++) begin
          ke_q[(j ^ 3) * 32 +: 32] <= Secret_key[KEY_LEN-1-32*j -: 32];
        end
      end else if (busy_q) begin
        ke_q[wr_off +: 32] <= word_d;
        win_q              <= {win_q[NK-2:0], word_d};
        if (idx_q[1:0] == 2'd3) vo_q[idx_q[5:2]] <= 1'b1;
        if (mod_q == '0) rcon_q <= rcon_d;
        mod_q <= (mod_q == MW'(NK-1)) ? '0 : mod_q + 1'b1;
        idx_q <= idx_q + 1'b1;
        if (idx_q == IW'(NW-1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign ready     = !busy_q;
  assign done      = done_q;
  assign key_expan = ke_q;
  assign valid_out = vo_q;

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// tb/tb_aes_key_schedule_iter.sv - self-checking bench for aes_key_schedule_iter (128/192/256)

module tb_aes_key_schedule_iter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [127:0]  key128;
  logic [191:0]  key192;
  logic [255:0]  key256;
  logic          vin128, vin192, vin256;
  logic          rdy128, rdy192, rdy256;
  logic          bsy128, bsy192, bsy256;
  logic          dn128, dn192, dn256;
  logic [1407:0] ke128;
  logic [1663:0] ke192;
  logic [1919:0] ke256;
  logic [10:0]   vo128;
  logic [12:0]   vo192;
  logic [14:0]   vo256;

  aes_key_schedule_iter #(.KEY_LEN(128)) u128 (
    .clk(clk), .reset(reset), .Secret_key(key128), .valid_in(vin128), .ready(rdy128),
    .busy(bsy128), .key_expan(ke128), .valid_out(vo128), .done(dn128));
  aes_key_schedule_iter #(.KEY_LEN(192)) u192 (
    .clk(clk), .reset(reset), .Secret_key(key192), .valid_in(vin192), .ready(rdy192),
    .busy(bsy192), .key_expan(ke192), .valid_out(vo192), .done(dn192));
  aes_key_schedule_iter #(.KEY_LEN(256)) u256 (
    .clk(clk), .reset(reset), .Secret_key(key256), .valid_in(vin256), .ready(rdy256),
    .busy(bsy256), .key_expan(ke256), .valid_out(vo256), .done(dn256));

  // observed instance: 0 -> 128, 1 -> 192, 2 -> 256
  int            sel;
  logic [1919:0] ke;
  logic [14:0]   vo;
  logic          rdy, bsy, dn;

  always_comb begin
    ke = '0; vo = '0; rdy = 1'b0; bsy = 1'b0; dn = 1'b0;
    case (sel)
      0: begin ke[1407:0] = ke128; vo[10:0] = vo128; rdy = rdy128; bsy = bsy128; dn = dn128; end
      1: begin ke[1663:0] = ke192; vo[12:0] = vo192; rdy = rdy192; bsy = bsy192; dn = dn192; end
      default: begin ke = ke256; vo = vo256; rdy = rdy256; bsy = bsy256; dn = dn256; end
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sbox [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nk_of(input int s);
    return 4 + 2 * s;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box table built by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  // reference key expansion over a plain word array
  function automatic logic [1919:0] model(input int nk, input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] r;
    int            nw;
    nw = 4 * (nk + 7);
    for (int j = 0; j < nk; j++) w[j] = key[32*(nk-1-j) +: 32];
    rc = 8'h01;
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = (rc << 1) ^ ((rc >= 8'h80) ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    r = '0;
    for (int rr = 0; rr < nk + 7; rr++) r[rr*128 +: 128] = {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
    return r;
  endfunction

  function automatic logic [14:0] vmask(input int nk, input int last_word);
    logic [14:0] m;
    m = '0;
    for (int r = 0; r < nk + 7; r++) if (4 * r + 3 <= last_word) m[r] = 1'b1;
    return m;
  endfunction

  task automatic drive(input int s, input logic [255:0] key, input logic v);
    case (s)
      0: begin key128 = key[127:0]; vin128 = v; end
      1: begin key192 = key[191:0]; vin192 = v; end
      default: begin key256 = key; vin256 = v; end
    endcase
  endtask

  // call at a negedge; returns at the negedge after the accepting edge E0
  task automatic start(input int s, input logic [255:0] key);
    drive(s, key, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(s, key, 1'b0);
    chk("vo_after_e0", vo, vmask(nk_of(s), nk_of(s) - 1));
  endtask

  // steps edges until done; optional valid_in pulse with another key before edge inject_k
  task automatic wait_done(input int s, input int inject_k, input logic [255:0] alt, output int lat);
    int nk, nw;
    nk  = nk_of(s);
    nw  = 4 * (nk + 7);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k == inject_k) drive(s, alt, 1'b1);
      @(posedge clk);
      @(negedge clk);
      if (k == inject_k) drive(s, alt, 1'b0);
      chk($sformatf("vo_k%0d", k), vo, vmask(nk, (nk + k - 1 < nw - 1) ? nk + k - 1 : nw - 1));
      chk($sformatf("busy_k%0d", k), bsy, (k < nw - nk));
      if (rdy === bsy) begin
        n_fail++;
        $display("FAIL ready_vs_busy k%0d: ready %b busy %b", k, rdy, bsy);
      end
      if (dn) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within 100 edges");
    end
  endtask

  task automatic check_result(input int s, input logic [255:0] key, input string tag);
    logic [1919:0] exp;
    exp = model(nk_of(s), key);
    for (int r = 0; r < nk_of(s) + 7; r++)
      chk($sformatf("%s_round%0d", tag, r), ke[r*128 +: 128], exp[r*128 +: 128]);
  endtask

  typedef struct {
    int           s;
    logic [255:0] key;
    logic [127:0] last_rk;
    int           lat;
    logic [14:0]  vo_final;
  } vec_t;

  vec_t          vt [4];
  int            lat;
  logic [255:0]  k1, k2, alt;

  initial begin
    vt[0] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c,
              128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 40, 15'h07ff};
    vt[1] = '{0, 256'h000102030405060708090a0b0c0d0e0f,
              128'h13111d7fe3944a17f307a78b4d2b30c5, 40, 15'h07ff};
    vt[2] = '{1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
              128'he98ba06f448c773c8ecc720401002202, 46, 15'h1fff};
    vt[3] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
              128'hfe4890d1e6188d0b046df344706c631e, 52, 15'h7fff};

    build_sbox();
    reset = 1'b1;
    sel = 0;
    key128 = '0; key192 = '0; key256 = '0;
    vin128 = 1'b0; vin192 = 1'b0; vin256 = 1'b0;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("rst_ke_zero_%0d", s), (ke == '0), 1'b1);
      chk($sformatf("rst_vo_%0d", s), vo, 15'h0);
      chk($sformatf("rst_ready_%0d", s), rdy, 1'b1);
      chk($sformatf("rst_busy_%0d", s), bsy, 1'b0);
      chk($sformatf("rst_done_%0d", s), dn, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // known-answer vectors
    for (int v = 0; v < 4; v++) begin
      sel = vt[v].s;
      start(vt[v].s, vt[v].key);
      wait_done(vt[v].s, 0, '0, lat);
      chk($sformatf("vec%0d_latency", v), lat, vt[v].lat);
      chk($sformatf("vec%0d_last_rk", v), ke[(nk_of(vt[v].s) + 6)*128 +: 128], vt[v].last_rk);
      chk($sformatf("vec%0d_vo_final", v), vo, vt[v].vo_final);
      check_result(vt[v].s, vt[v].key, $sformatf("vec%0d", v));
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", v), dn, 1'b0);
      chk($sformatf("vec%0d_vo_sticky", v), vo, vt[v].vo_final);
    end

    // mid-run key request ignored, then a key accepted in the done cycle
    sel = 0;
    k1  = vt[0].key;
    k2  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    alt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start(0, k1);
    wait_done(0, 10, alt, lat);
    chk("ignore_latency", lat, 40);
    check_result(0, k1, "ignore");
    drive(0, k2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, k2, 1'b0);
    chk("restart_vo", vo, 15'h0001);
    chk("restart_busy", bsy, 1'b1);
    wait_done(0, 0, '0, lat);
    chk("restart_latency", lat, 40);
    check_result(0, k2, "restart");

    // reset in the middle of a run
    @(negedge clk);
    start(0, k1);
    for (int k = 1; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_ke_zero", (ke == '0), 1'b1);
    chk("abort_vo", vo, 15'h0);
    chk("abort_ready", rdy, 1'b1);
    chk("abort_busy", bsy, 1'b0);
    chk("abort_done", dn, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", dn, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    start(0, k1);
    wait_done(0, 0, '0, lat);
    chk("post_abort_latency", lat, 40);
    chk("post_abort_last_rk", ke[10*128 +: 128], vt[0].last_rk);
    check_result(0, k1, "post_abort");

    // random keys for every key length
    for (int s = 0; s < 3; s++) begin
      for (int t = 0; t < 3; t++) begin
        @(negedge clk);
        sel = s;
        k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start(s, k1);
        wait_done(s, 0, '0, lat);
        chk($sformatf("rand%0d_%0d_latency", s, t), lat, 4 * (nk_of(s) + 7) - nk_of(s));
        check_result(s, k1, $sformatf("rand%0d_%0d", s, t));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_iter.md
Name: aes_key_schedule_iter

Overview:
Iterative AES key-expansion engine for 128-, 192- and 256-bit keys, selected at elaboration by KEY_LEN.
It accepts a cipher key through a valid/ready handshake and produces one 32-bit schedule word per clock, following FIPS-197.
All round keys are presented on a flat bus, with a per-round valid vector and a completion pulse.
It feeds the encrypt and decrypt round pipelines and replaces the fixed 128-bit/10-round expander.

Parameters:
KEY_LEN, 128, cipher key width; legal values are 128, 192 and 256; any other value is an elaboration error.
NK, KEY_LEN/32, key length in words (derived; do not override).
NR, NK+6, number of rounds: 10, 12 or 14 (derived).
NW, 4*(NR+1), total schedule words: 44, 52 or 60 (derived).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
Secret_key  in  KEY_LEN  cipher key; bits [KEY_LEN-1 -:32] are w[0] (FIPS-197 byte order, MSB first)
valid_in  in  1  key-load request
ready  out  1  high when the block can accept a key; equals !busy
busy  out  1  expansion in progress
key_expan  out  (NR+1)*128  round key r at [r*128 +:128], holding {w[4r],w[4r+1],w[4r+2],w[4r+3]} with w[4r] in the MSBs
valid_out  out  NR+1  bit r set when round key r is complete
done  out  1  one-cycle pulse when the last word has been written

Behaviour:
- Reset (async, active-high):
  - key_expan = 0, valid_out = 0, busy = 0, done = 0, ready = 1.
  - Word counter, mod-NK counter and Rcon register are cleared; Rcon is set to 8'h01 on the next start.
- Accept: valid_in && ready at a rising edge (edge E0).
  - Load w[0..NK-1] from Secret_key.
  - Clear valid_out, then set the bits of rounds fully covered by the raw key: round 0 for NK=4 or 6; rounds 0 and 1 for NK=8.
  - busy = 1. Word index i = NK. Rcon = 01.
- Generate: on each edge Ek (k ≥ 1) while busy, write word i = NK+k-1, then i++.
  - temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}; then Rcon = xtime(Rcon), with a 0x1b reduction when bit 7 is set.
  - Else if NK==8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - Track i mod NK with a wrap counter, not a divider.
- SubWord uses 4 instances of the team's combinational AES S-box. Only one word is computed per cycle, so there is no other S-box sharing.
- valid_out[r] is set on the edge that writes w[4r+3]. Bits are sticky until the next accept or reset.
- Completion: the last word w[NW-1] is written at edge E_(NW-NK), i.e. 40, 46 or 52 edges after E0.
  - On that edge: busy = 0 and done = 1 for exactly one cycle.
  - Total key-to-done latency: 41, 47 or 53 cycles counted from E0 inclusive.
- valid_in while busy: ignored. No restart, no change to state.
- valid_in on the same edge that writes the last word: ignored, because ready is still 0 at that edge.
- valid_in in the cycle done is high: accepted normally, since ready = 1. The old key_expan is overwritten progressively and valid_out restarts from its reset pattern.
- Secret_key is sampled only at E0; later changes have no effect.
- Reset asserted mid-expansion: immediate abort, all outputs return to reset values, and done never pulses.
- key_expan words not yet written in the current run keep their prior contents. Consumers must qualify them with valid_out.

Test Plan:
1. KEY_LEN=128, key 2b7e151628aed2a6abf7158809cf4f3c -> round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done exactly 40 edges after E0; valid_out = 11'h7FF.
2. KEY_LEN=128, key 000102030405060708090a0b0c0d0e0f -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5; valid_out[1] set at E4 and valid_out[r] set at E(4r) (r ≥ 1).
3. KEY_LEN=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> round 12 = e98ba06f448c773c8ecc720401002202; done at E46; valid_out = 13'h1FFF.
4. KEY_LEN=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> round 14 = fe4890d1e6188d0b046df344706c631e; done at E52; valid_out = 15'h0003 immediately after E0.
5. KEY_LEN=128, pulse valid_in with a different key at E10 mid-run -> ignored and results identical to scenario 1; then a new key during the done cycle -> accepted, valid_out = 1 after that edge, second result correct.
6. Assert reset at E20 of a 128-bit run -> all outputs 0 and ready = 1 at once, no done pulse; a fresh start afterwards gives the scenario 1 values.
